// File: rtl/fp32_add_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, the shared fp32 adder
// arbiter, and the single result consumer.
interface fp32_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     nan_flag;
  logic                     nan_clr;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, nan_clr,
    input  req_ready, rsp_valid, rsp_data, rsp_id, nan_flag, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, nan_clr,
    output req_ready, rsp_valid, rsp_data, rsp_id, nan_flag, busy
  );
endinterface

// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter feeding one shared combinational fp32 adder through a
// two-stage valid/ready pipeline, with a sticky NaN flag on the result side.

module fp32_add (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic              w_aNan, w_bNan, w_aInf, w_bInf, w_swap, w_effSub;
  logic [31:0]       w_big, w_small;
  logic [7:0]        w_bigExp, w_smallExp, w_expDiff;
  logic [47:0]       w_bigMant, w_smallMant, w_alignMant;
  logic [48:0]       w_mantSum, w_normMant;
  logic [5:0]        w_leadPos;
  logic signed [9:0] w_normExp;
  logic              w_unusedBits;

  assign w_aNan = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
  assign w_bNan = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);
  assign w_aInf = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
  assign w_bInf = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);

  // Order by magnitude so the subtraction below never goes negative.
  assign w_swap  = i_b[30:0] > i_a[30:0];
  assign w_big   = w_swap ? i_b : i_a;
  assign w_small = w_swap ? i_a : i_b;

  assign w_bigExp    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
  assign w_smallExp  = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
  assign w_expDiff   = w_bigExp - w_smallExp;
  assign w_bigMant   = {w_big[30:23] != 8'd0, w_big[22:0], 24'd0};
  assign w_smallMant = {w_small[30:23] != 8'd0, w_small[22:0], 24'd0};
  assign w_alignMant = (w_expDiff >= 8'd48) ? 48'd0 : (w_smallMant >> w_expDiff);
  assign w_effSub    = w_big[31] ^ w_small[31];
  assign w_mantSum   = w_effSub ? ({1'b0, w_bigMant} - {1'b0, w_alignMant})
                                : ({1'b0, w_bigMant} + {1'b0, w_alignMant});

  always_comb begin
    w_leadPos = 6'd0;
    for (int i = 0; i < 49; i++) begin
      if (w_mantSum[i]) w_leadPos = 6'(i);
    end
  end

  // Hidden bit is renormalised to position 47; low bits are simply truncated.
  always_comb begin
    w_normMant = '0;
    w_normExp  = 10'sd0;
    if (w_leadPos == 6'd48) begin
      w_normMant = w_mantSum >> 1;
      w_normExp  = $signed({2'b00, w_bigExp}) + 10'sd1;
    end else begin
      w_normMant = w_mantSum << (6'd47 - w_leadPos);
      w_normExp  = $signed({2'b00, w_bigExp}) - $signed({4'b0000, 6'd47 - w_leadPos});
    end
  end

  assign w_unusedBits = ^{w_normMant[48:47], w_normMant[23:0]};

  always_comb begin
    o_sum = QNAN;
    if (w_aNan || w_bNan || (w_aInf && w_bInf && (i_a[31] != i_b[31]))) begin
      o_sum = QNAN;
    end else if (w_aInf) begin
      o_sum = i_a;
    end else if (w_bInf) begin
      o_sum = i_b;
    end else if (w_mantSum == 49'd0) begin
      o_sum = {w_big[31] & w_small[31], 31'd0};
    end else if (w_normExp >= 10'sd255) begin
      o_sum = {w_big[31], 8'hFF, 23'd0};
    end else if (w_normExp <= 10'sd0) begin
      o_sum = {w_big[31], 31'd0};
    end else begin
      o_sum = {w_big[31], w_normExp[7:0], w_normMant[46:24]};
    end
  end
endmodule

module fp32_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  fp32_add_arbiter_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [ID_W-1:0]  r_ptr;
  logic             r_s1Valid, r_s2Valid, r_nanFlag;
  logic [WIDTH-1:0] r_s1A, r_s1B, r_rspData;
  logic [ID_W-1:0]  r_s1Id, r_rspId;

  logic             w_s2Adv, w_s1Free, w_anyValid, w_xfer;
  logic [ID_W-1:0]  w_win, w_cand, w_nextPtr;
  logic [WIDTH-1:0] w_selA, w_selB, w_sum;

  assign w_s2Adv  = r_s1Valid & (~r_s2Valid | bus.rsp_ready);
  assign w_s1Free = ~r_s1Valid | w_s2Adv;

  // Walking the search order backwards lets the earliest valid candidate win.
  always_comb begin
    w_anyValid = 1'b0;
    w_win      = '0;
    w_cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (bus.req_valid[w_cand]) begin
        w_anyValid = 1'b1;
        w_win      = w_cand;
      end
    end
  end

  assign w_xfer    = w_anyValid & w_s1Free;
  assign w_nextPtr = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);

  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) bus.req_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_selA = '0;
    w_selB = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == ID_W'(k)) begin
        w_selA = bus.req_a[k*WIDTH +: WIDTH];
        w_selB = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  fp32_add u_add (
    .i_a   (r_s1A),
    .i_b   (r_s1B),
    .o_sum (w_sum)
  );

  // S2 only loads on advance, which keeps the response frozen under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_s1Valid <= 1'b0;
      r_s1A     <= '0;
      r_s1B     <= '0;
      r_s1Id    <= '0;
      r_s2Valid <= 1'b0;
      r_rspData <= '0;
      r_rspId   <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr     <= w_nextPtr;
        r_s1Valid <= 1'b1;
        r_s1A     <= w_selA;
        r_s1B     <= w_selB;
        r_s1Id    <= w_win;
      end else if (w_s1Free) begin
        r_s1Valid <= 1'b0;
      end
      if (w_s2Adv) begin
        r_s2Valid <= 1'b1;
        r_rspData <= w_sum;
        r_rspId   <= r_s1Id;
      end else if (bus.rsp_ready) begin
        r_s2Valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nanFlag <= 1'b0;
    end else if (bus.nan_clr) begin
      r_nanFlag <= 1'b0;
    end else if (r_s2Valid && bus.rsp_ready && (r_rspData == QNAN)) begin
      r_nanFlag <= 1'b1;
    end
  end

  assign bus.rsp_valid = r_s2Valid;
  assign bus.rsp_data  = r_rspData;
  assign bus.rsp_id    = r_rspId;
  assign bus.nan_flag  = r_nanFlag;
  assign bus.busy      = r_s1Valid | r_s2Valid;
endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter: reset, single add, round robin,
// backpressure, sticky NaN, cancellation and mid-operation reset.
module tb_fp32_add_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   nCompared = 0;
  int   nMismatched = 0;

  fp32_add_arbiter_if #(.NUM_REQ(N), .WIDTH(32)) bus ();

  fp32_add_arbiter #(.NUM_REQ(N), .WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setOps(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[id*32 +: 32] = a;
    bus.req_b[id*32 +: 32] = b;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b0; bus.nan_clr = 1'b0;
    #3;
    nCompared++; if (bus.req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    nCompared++; if (bus.rsp_data !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
    nCompared++; if (bus.rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", bus.rsp_id); end
    nCompared++; if (bus.nan_flag !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_nan_flag: got %b expected 0", bus.nan_flag); end
    nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    setOps(0, 32'h3F800000, 32'h40000000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    nCompared++; if (bus.req_ready !== 4'b0001) begin nMismatched++; $display("[TB] FAIL single_grant: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_early_valid: got %b expected 0", bus.rsp_valid); end
    nCompared++; if (bus.busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_busy: got %b expected 1", bus.busy); end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_valid: got %b expected 1", bus.rsp_valid); end
    nCompared++; if (bus.rsp_data !== 32'h40400000) begin nMismatched++; $display("[TB] FAIL single_data: got %h expected 40400000", bus.rsp_data); end
    nCompared++; if (bus.rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL single_id: got %0d expected 0", bus.rsp_id); end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_drain: got %b expected 0", bus.rsp_valid); end
    nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] opA [4];
    logic [31:0] expSum [4];
    logic [3:0]  expGrant;
    opA    = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    expSum = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    doReset();
    for (int i = 0; i < N; i++) setOps(i, opA[i], 32'h3F800000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int e = 0; e <= 6; e++) begin
      if (e < 6) begin
        #1;
        expGrant = 4'(1 << (e % 4));
        nCompared++; if (bus.req_ready !== expGrant) begin nMismatched++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", e, bus.req_ready, expGrant); end
      end else begin
        bus.req_valid = '0;
      end
      tick();
      if (e >= 1) begin
        nCompared++; if (bus.rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rr_valid[%0d]: got %b expected 1", e, bus.rsp_valid); end
        nCompared++; if (bus.rsp_id !== 2'((e - 1) % 4)) begin nMismatched++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", e, bus.rsp_id, (e - 1) % 4); end
        nCompared++; if (bus.rsp_data !== expSum[(e - 1) % 4]) begin nMismatched++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", e, bus.rsp_data, expSum[(e - 1) % 4]); end
      end
    end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rr_drain: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure();
    doReset();
    setOps(1, 32'h3F800000, 32'h3F800000);
    setOps(2, 32'h40000000, 32'h40000000);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0110;
    #1;
    nCompared++; if (bus.req_ready !== 4'b0010) begin nMismatched++; $display("[TB] FAIL bp_grant1: got %b expected 0010", bus.req_ready); end
    tick();
    #1;
    nCompared++; if (bus.req_ready !== 4'b0100) begin nMismatched++; $display("[TB] FAIL bp_grant2: got %b expected 0100", bus.req_ready); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      nCompared++; if (bus.req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL bp_stall_ready[%0d]: got %b expected 0000", c, bus.req_ready); end
      nCompared++; if (bus.rsp_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_stall_valid[%0d]: got %b expected 1", c, bus.rsp_valid); end
      nCompared++; if (bus.rsp_id !== 2'd1) begin nMismatched++; $display("[TB] FAIL bp_stall_id[%0d]: got %0d expected 1", c, bus.rsp_id); end
      nCompared++; if (bus.rsp_data !== 32'h40000000) begin nMismatched++; $display("[TB] FAIL bp_stall_data[%0d]: got %h expected 40000000", c, bus.rsp_data); end
      tick();
    end
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b1;
    #1;
    nCompared++; if (bus.req_ready !== 4'b0010) begin nMismatched++; $display("[TB] FAIL bp_recover_grant: got %b expected 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    nCompared++; if (bus.rsp_id !== 2'd2) begin nMismatched++; $display("[TB] FAIL bp_second_id: got %0d expected 2", bus.rsp_id); end
    nCompared++; if (bus.rsp_data !== 32'h40800000) begin nMismatched++; $display("[TB] FAIL bp_second_data: got %h expected 40800000", bus.rsp_data); end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1) begin nMismatched++; $display("[TB] FAIL bp_third: got valid %b id %0d expected valid 1 id 1", bus.rsp_valid, bus.rsp_id); end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_drain: got %b expected 0", bus.rsp_valid); end
  endtask

  task automatic test_nan_sticky();
    setOps(3, 32'h7F800000, 32'hFF800000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    nCompared++; if (bus.req_ready !== 4'b1000) begin nMismatched++; $display("[TB] FAIL nan_grant: got %b expected 1000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    nCompared++; if (bus.rsp_data !== 32'h7FC00000) begin nMismatched++; $display("[TB] FAIL nan_data: got %h expected 7fc00000", bus.rsp_data); end
    nCompared++; if (bus.rsp_id !== 2'd3) begin nMismatched++; $display("[TB] FAIL nan_id: got %0d expected 3", bus.rsp_id); end
    nCompared++; if (bus.nan_flag !== 1'b0) begin nMismatched++; $display("[TB] FAIL nan_early: got %b expected 0", bus.nan_flag); end
    tick();
    nCompared++; if (bus.nan_flag !== 1'b1) begin nMismatched++; $display("[TB] FAIL nan_set: got %b expected 1", bus.nan_flag); end
    tick();
    nCompared++; if (bus.nan_flag !== 1'b1) begin nMismatched++; $display("[TB] FAIL nan_sticky: got %b expected 1", bus.nan_flag); end
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    tick();
    bus.nan_clr = 1'b1;
    #1;
    nCompared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h7FC00000) begin nMismatched++; $display("[TB] FAIL nan_second: got valid %b data %h expected valid 1 data 7fc00000", bus.rsp_valid, bus.rsp_data); end
    tick();
    bus.nan_clr = 1'b0;
    nCompared++; if (bus.nan_flag !== 1'b0) begin nMismatched++; $display("[TB] FAIL nan_clr_priority: got %b expected 0", bus.nan_flag); end
    tick();
    nCompared++; if (bus.nan_flag !== 1'b0) begin nMismatched++; $display("[TB] FAIL nan_clr_hold: got %b expected 0", bus.nan_flag); end
  endtask

  task automatic test_cancellation();
    setOps(3, 32'h3F800000, 32'h40000000);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    #1;
    nCompared++; if (bus.req_ready !== 4'b1000) begin nMismatched++; $display("[TB] FAIL cancel_fill1: got %b expected 1000", bus.req_ready); end
    tick();
    tick();
    bus.req_valid = 4'b0100;
    #1;
    nCompared++; if (bus.req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL cancel_blocked: got %b expected 0000", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    setOps(0, 32'h3F800000, 32'h3F800000);
    setOps(1, 32'h40000000, 32'h40000000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0011;
    #1;
    nCompared++; if (bus.req_ready !== 4'b0001) begin nMismatched++; $display("[TB] FAIL cancel_ptr_kept: got %b expected 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    nCompared++; if (bus.rsp_id !== 2'd3 || bus.rsp_data !== 32'h40400000) begin nMismatched++; $display("[TB] FAIL cancel_r3: got id %0d data %h expected id 3 data 40400000", bus.rsp_id, bus.rsp_data); end
    tick();
    nCompared++; if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 32'h40000000) begin nMismatched++; $display("[TB] FAIL cancel_r0: got id %0d data %h expected id 0 data 40000000", bus.rsp_id, bus.rsp_data); end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL cancel_no_id2: got valid %b busy %b expected 0 0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_reset_mid();
    setOps(3, 32'h7F800000, 32'hFF800000);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    nCompared++; if (bus.nan_flag !== 1'b1) begin nMismatched++; $display("[TB] FAIL rm_pre_nan: got %b expected 1", bus.nan_flag); end
    for (int i = 0; i < 3; i++) setOps(i, 32'h3F800000, 32'h3F800000);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    tick();
    tick();
    #1;
    nCompared++; if (bus.rsp_valid !== 1'b1 || bus.busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL rm_full: got valid %b busy %b expected 1 1", bus.rsp_valid, bus.busy); end
    rst_n = 1'b0;
    #1;
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_rsp_valid: got %b expected 0", bus.rsp_valid); end
    nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_busy: got %b expected 0", bus.busy); end
    nCompared++; if (bus.nan_flag !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_nan_flag: got %b expected 0", bus.nan_flag); end
    #2;
    rst_n = 1'b1;
    #1;
    nCompared++; if (bus.req_ready !== 4'b0001) begin nMismatched++; $display("[TB] FAIL rm_first_grant: got %b expected 0001", bus.req_ready); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL rm_first_rsp: got valid %b id %0d expected valid 1 id 0", bus.rsp_valid, bus.rsp_id); end
    tick();
    nCompared++; if (bus.rsp_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_drain: got %b expected 0", bus.rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_nan_sticky();
    test_cancellation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/fp32_add_arbiter.md
# fp32_add_arbiter

Round-robin arbiter and two-stage pipeline that shares one combinational `fp32_add` instance (FORMAT "FP32") among `NUM_REQ` requesters in the tensorcore. Each requester presents an operand pair with a valid/ready handshake. The block registers the granted operands, computes the sum, and returns the result with the requester ID on a single response channel with backpressure. It also keeps a sticky NaN flag for software.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WIDTH`, 32: operand width; only 32 is supported.
- `ID_W`, `$clog2(NUM_REQ)`: requester ID width.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester operand-pair valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  operand B, same packing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_data`  out  WIDTH  fp32 sum.
- `rsp_id`  out  ID_W  index of the requester that issued the operands.
- `nan_flag`  out  1  sticky; set when an accepted response equals 32'h7FC00000.
- `nan_clr`  in  1  synchronous clear of `nan_flag`.
- `busy`  out  1  high when s1_valid or s2_valid is high.

## Operation
- **Stage 1 (S1):** registers `s1_a`, `s1_b`, `s1_id` and `s1_valid`.
- **Stage 2 (S2):** registers `fp32_add(s1_a, s1_b)` into `rsp_data`, copies `s1_id` into `rsp_id`, and drives `rsp_valid` from `s2_valid`.
- **Advance rules:**
  - s2_adv = s1_valid & (!s2_valid | rsp_ready).
  - s1_free = !s1_valid | s2_adv.
- **Arbitration:**
  - `ptr` is an ID_W round-robin pointer.
  - Search order is ptr, ptr+1, … wrapping modulo NUM_REQ.
  - The first requester with `req_valid` high wins.
  - `req_ready[win]` = s1_free. All other `req_ready` bits are 0.
  - No `req_ready` bit is asserted when no requester has `req_valid` high.
- **Handshake:** a transfer occurs when `req_valid[i]` & `req_ready[i]`.
  - On a transfer, S1 loads that requester's operands and ID.
  - On a transfer, `ptr` becomes win+1, wrapping from NUM_REQ-1 to 0.
  - `ptr` does not change in any cycle without a transfer.
- **Requester rule:** a requester holds `req_valid` and its operands stable until accepted. The arbiter does not depend on stability across cycles and re-arbitrates every cycle.
- **S1 valid update:**
  - When s1_free and no transfer occurs, `s1_valid` clears.
  - Otherwise `s1_valid` holds.
- **S2 valid update:**
  - On s2_adv, `s2_valid` is set.
  - Otherwise, when `rsp_ready` is high, `s2_valid` clears.
  - Otherwise `s2_valid` holds.
- **Output stability:** while `rsp_valid` is high and `rsp_ready` is low, `rsp_data` and `rsp_id` are frozen.
- **NaN flag:**
  - Set on a response handshake (`rsp_valid` & `rsp_ready`) where `rsp_data` == 32'h7FC00000.
  - `nan_clr` has priority over a set in the same cycle.
- **Arithmetic:** the block passes the adder result through unmodified.
  - Special values (NaN, ±inf, zeros) follow the adder's rules.
  - Truncating normalisation and flush-to-zero of denormal results are not corrected here.

## Timing
- **Reset values:**
  - Outputs: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `nan_flag`=0, `busy`=0.
  - Internal state: `ptr`=0, `s1_valid`=0, `s2_valid`=0.
- **Latency:** an operand transfer at edge T gives `rsp_valid` high after edge T+1, i.e. usable in the cycle following T+1.
- **Throughput:** one result per cycle with `rsp_ready` held high.
- **Full backpressure:** with `rsp_ready` low, at most 2 transfers complete. After that `req_ready` stays 0 until `rsp_ready` returns.
- **Recovery from a full pipe:** when `rsp_ready` rises with both stages full, a new transfer is accepted in that same cycle. There is no bubble.
- **Combinational paths:**
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`.
  - There is no combinational path from `req_*` to `rsp_*`.
- **Reset mid-operation:** asserting `rst_n` low clears everything immediately, whatever the pipe contents.
  - In-flight results are dropped.
  - After release, arbitration restarts with `ptr`=0.

## Test plan
- **Single add:** requester 0 sends a=32'h3F800000, b=32'h40000000 with `rsp_ready`=1.
  - Expect `rsp_valid` 2 cycles after the accept.
  - Expect `rsp_data`=32'h40400000 and `rsp_id`=0.
- **Round robin:** all 4 requesters hold `req_valid`=1 continuously with `rsp_ready`=1.
  - Expect grants in order 0,1,2,3,0,1.
  - Expect back-to-back responses with IDs in the same order and no gaps.
- **Backpressure:** hold `rsp_ready`=0 with requesters 1 and 2 valid.
  - Expect exactly two transfers (ID 1, then ID 2), after which `req_ready` stays 0.
  - Expect `rsp_data`/`rsp_id` frozen while stalled.
  - Raise `rsp_ready`: expect the ID 1 response, then the ID 2 response, and a new transfer in the same cycle `rsp_ready` rises.
- **NaN sticky:** requester 3 sends 32'h7F800000 + 32'hFF800000.
  - Expect `rsp_data`=32'h7FC00000 and `nan_flag`=1 from the cycle after the handshake.
  - Assert `nan_clr` together with a second NaN handshake: expect `nan_flag`=0.
- **Cancellation:** requester 2 raises `req_valid` and drops it before being granted.
  - Expect no response with ID 2.
  - Expect `ptr` unchanged: the next grant with 0 and 1 valid goes to 0 when ptr=0.
- **Reset mid-operation:** pulse `rst_n` low with both stages full.
  - Expect `rsp_valid`=0, `busy`=0 and `nan_flag`=0 immediately.
  - Expect the first grant after release to requester 0 when all requesters are valid.
